fetch_responder: RTL and testbench
==================================

// Module: fetch_responder
// PURPOSE
//  Instruction-memory responder for the fetch stage. It accepts PC requests on a valid/ready slave port.
//  It reads a word from an internal instruction RAM and returns instruction + error flag on a valid/ready
//  master port, in request order. A credit-gated response FIFO absorbs backpressure. A flush port discards
//  in-flight fetches on redirect.
// PARAMETERS
//  XLEN        32   address/data width (from k11_pkg)
//  DEPTH_LOG2  10   log2 of RAM depth in 32-bit words (4 KiB)
//  FIFO_DEPTH  4    response FIFO entries, power of two, >=2; also max outstanding requests
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst_n        in   1           asynchronous active-low reset
//  req_valid_i  in   1           fetch request valid
//  req_ready_o  out  1           request accepted when valid&ready
//  req_addr_i   in   XLEN        byte address of instruction
//  rsp_valid_ro out  1           response valid (registered)
//  rsp_ready_i  in   1           consumer accepts response
//  rsp_data_ro  out  XLEN        instruction word (registered)
//  rsp_err_ro   out  1           1 = misaligned or out-of-range access
//  flush_i      in   1           drop all in-flight and queued responses
//  load_we_i    in   1           RAM write strobe (program load)
//  load_addr_i  in   DEPTH_LOG2  word address for load
//  load_data_i  in   XLEN        word to write
// BEHAVIOUR
//  - Reset: rsp_valid_ro=0, rsp_data_ro=0, rsp_err_ro=0, read-stage valid=0, FIFO empty, inflight=0.
//    RAM contents are not reset.
//  - Accept: fire = req_valid_i & req_ready_o. The RAM is read at the fire edge into the read stage
//    (rd_valid/rd_data/rd_err). The read stage pushes into the FIFO on the next edge.
//  - Latency: fire at edge N -> rsp_valid_ro high after edge N+2 (min). Sustained throughput is
//    1 response/cycle while rsp_ready_i=1.
//  - Credit: inflight = rd_valid + fifo_count. req_ready_o = (inflight < FIFO_DEPTH) & ~flush_i.
//    req_ready_o has no combinational dependence on rsp_ready_i or req_valid_i.
//  - Inflight update: +1 on fire, -1 on response pop (rsp_valid_ro & rsp_ready_i). A simultaneous
//    fire and pop leaves inflight unchanged. The FIFO therefore never overflows.
//  - Error: rsp_err_ro=1 when req_addr_i[1:0]!=0 or req_addr_i[XLEN-1:DEPTH_LOG2+2]!=0. On error,
//    rsp_data_ro=32'h0000_0013 (NOP from k11_pkg). Erroneous requests still consume a slot and return
//    in order.
//  - Output hold: while rsp_valid_ro=1 & rsp_ready_i=0, rsp_data_ro and rsp_err_ro are stable.
//  - Ordering: responses are strictly FIFO in acceptance order. The FIFO has write/read pointers
//    of log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty, and the pointers wrap naturally.
//  - Flush (sampled at edge): rd_valid<=0, FIFO emptied, rsp_valid_ro<=0, inflight<=0.
//    * No request is accepted in the flush cycle.
//    * A pop coinciding with flush_i still completes; the consumer sees that handshake.
//    * The first post-flush request may fire the cycle after flush_i drops.
//  - Load port: write at edge. Load and fetch of the same word in the same cycle returns OLD data
//    (read-before-write). The load port is independent of the handshakes and of flush_i.
//  - Async reset asserted mid-transfer: all outstanding requests are lost, and outputs go to reset
//    values immediately. Reset release is synchronised externally.
// STRUCTURE
//  - k11_pkg: XLEN, INSN_NOP (32'h0000_0013), handshake typedef rsp_t {data[XLEN-1:0], err}.
//  - Sub-module resp_fifo (FIFO_DEPTH x rsp_t, registered head output, count output, sync clear).
//  - Top holds RAM array, read stage, credit counter.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid_i=1 -> rsp_valid_ro=0, req_ready_o=1 after release.
//  2 Stream: preload words 0..7 = i*3+1; request addr 0,4,...,28 back-to-back with rsp_ready_i=1
//    -> 8 responses, data 1,4,...,22, first at cycle 2, one per cycle, err=0.
//  3 Backpressure: rsp_ready_i=0, issue 6 requests -> exactly 4 accepted, req_ready_o=0 thereafter,
//    head data stable. Raise ready -> 4 in-order pops, then the remaining 2 accepted.
//  4 Errors: addr 0x2 -> err=1, data=0x13. addr 0x1000 (DEPTH_LOG2=10) -> err=1.
//    addr 0xFFC -> err=0, word 1023.
//  5 Flush: 3 in flight, flush_i 1 cycle with req_valid_i=1 -> no response appears.
//    Next request addr 8 returns word 2 only.
//  6 Load collision: RAM[5]=A; same cycle load 5<=B and fetch 0x14 -> response A.
//    Refetch 0x14 -> B.

Source files
------------

// File: rtl/k11_pkg.sv
// Shared fetch-path definitions: data width, canonical NOP and the
// response bundle carried from the read stage to the consumer.
package k11_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Response queue with a registered head: storage ring plus one output
// register, so the consumer never sees a combinational RAM read path.
module resp_fifo
  import k11_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  rsp_t                   push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output rsp_t                   head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  rsp_t        r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_valid;
  rsp_t        r_head;

  logic [AW:0] w_used;
  logic        w_pop;
  logic        w_take;

  assign w_used = r_wptr - r_rptr;
  assign w_pop  = pop_i & r_valid;
  // refill the head whenever it is empty or being consumed this edge
  assign w_take = (w_used != '0) & (~r_valid | w_pop);

  always_ff @(posedge clk) begin
    if (push_i & ~clr_i) begin
      r_mem[r_wptr[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (push_i) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_take) begin
        r_head  <= r_mem[r_rptr[AW-1:0]];
        r_rptr  <= r_rptr + (AW+1)'(1);
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o = r_valid;
  assign head_o  = r_head;
  assign count_o = w_used + {{AW{1'b0}}, r_valid};

endmodule

// File: rtl/fetch_responder.sv
// Instruction-memory responder: RAM read stage feeding a credit-gated
// response queue, with flush on redirect and a program-load write port.
module fetch_responder
  import k11_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [XLEN-1:0]       req_addr_i,
  output logic                  rsp_valid_ro,
  input  logic                  rsp_ready_i,
  output logic [XLEN-1:0]       rsp_data_ro,
  output logic                  rsp_err_ro,
  input  logic                  flush_i,
  input  logic                  load_we_i,
  input  logic [DEPTH_LOG2-1:0] load_addr_i,
  input  logic [XLEN-1:0]       load_data_i
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_ram [WORDS];
  logic            r_rd_valid;
  rsp_t            r_rd;

  logic                  w_fire;
  logic                  w_pop;
  logic                  w_err;
  logic                  w_ready;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic [CW:0]           w_count;
  logic [CW:0]           w_inflight;
  logic                  w_head_valid;
  rsp_t                  w_head;

  assign w_widx = req_addr_i[DEPTH_LOG2+1:2];
  assign w_err  = (req_addr_i[1:0] != 2'b00) |
                  (req_addr_i[XLEN-1:DEPTH_LOG2+2] != '0);

  // every accepted fetch holds a slot until the consumer pops it
  assign w_inflight = w_count + {{CW{1'b0}}, r_rd_valid};
  assign w_ready    = (w_inflight < CREDITS) & ~flush_i;
  assign w_fire     = req_valid_i & w_ready;
  assign w_pop      = w_head_valid & rsp_ready_i;

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      r_ram[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd       <= '0;
    end else begin
      r_rd_valid <= w_fire;
      if (w_fire) begin
        r_rd.err  <= w_err;
        r_rd.data <= w_err ? INSN_NOP : r_ram[w_widx];
      end
    end
  end

  resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush_i),
    .push_i      (r_rd_valid),
    .push_data_i (r_rd),
    .pop_i       (w_pop),
    .valid_o     (w_head_valid),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign req_ready_o  = w_ready;
  assign rsp_valid_ro = w_head_valid;
  assign rsp_data_ro  = w_head.data;
  assign rsp_err_ro   = w_head.err;

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed tables plus random traffic against
// a queue-based reference model.
module tb_fetch_responder;
  import k11_pkg::*;

  localparam int DL = 10;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        rsp_valid_ro;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_ro;
  logic        rsp_err_ro;
  logic        flush_i = 1'b0;
  logic        load_we_i = 1'b0;
  logic [9:0]  load_addr_i = '0;
  logic [31:0] load_data_i = '0;

  always #5 clk = ~clk;

  fetch_responder #(
    .DEPTH_LOG2 (DL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .rsp_valid_ro (rsp_valid_ro),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_ro  (rsp_data_ro),
    .rsp_err_ro   (rsp_err_ro),
    .flush_i      (flush_i),
    .load_we_i    (load_we_i),
    .load_addr_i  (load_addr_i),
    .load_data_i  (load_data_i)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          vis;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } tv_t;

  exp_t        q[$];
  logic [31:0] mram [1024];
  tv_t         tbl [8];
  int          nvec = 0;
  int          nfail = 0;
  int          edge_n = 0;
  int          npop = 0;
  bit          got = 0;
  bit          last_fire = 0;
  logic [31:0] pop_d = '0;
  logic        pop_e = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a);
    exp_t r;
    r.e   = (a % 4 != 0) || (a >= 32'h1000);
    r.d   = r.e ? 32'h13 : mram[a / 4];
    r.vis = 0;
    return r;
  endfunction

  task automatic cycle(input bit v, input logic [31:0] a, input bit rr,
                       input bit fl, input bit we, input logic [9:0] la,
                       input logic [31:0] ld);
    bit   ev;
    bit   pop;
    bit   fire;
    bit   rdy;
    exp_t n;
    req_valid_i = v;
    req_addr_i  = a;
    rsp_ready_i = rr;
    flush_i     = fl;
    load_we_i   = we;
    load_addr_i = la;
    load_data_i = ld;
    #1;
    rdy  = !fl && (q.size() < FD);
    fire = v && rdy;
    chk("req_ready", 32'(req_ready_o), 32'(rdy));
    ev = (q.size() > 0) && (q[0].vis <= edge_n);
    chk("rsp_valid", 32'(rsp_valid_ro), 32'(ev));
    if (ev) begin
      chk("rsp_data", rsp_data_ro, q[0].d);
      chk("rsp_err", 32'(rsp_err_ro), 32'(q[0].e));
    end
    pop = ev && rr;
    if (pop) begin
      got   = 1;
      pop_d = rsp_data_ro;
      pop_e = rsp_err_ro;
    end
    n = mk(a);
    n.vis = edge_n + 3;
    @(posedge clk);
    edge_n++;
    if (pop) begin
      void'(q.pop_front());
      npop++;
    end
    if (fl) q.delete();
    if (fire) q.push_back(n);
    if (we) mram[la] = ld;
    last_fire = fire;
    @(negedge clk);
  endtask

  task automatic fetch1(input logic [31:0] a, input bit we,
                        input logic [9:0] la, input logic [31:0] ld,
                        output logic [31:0] d, output logic e);
    got = 0;
    cycle(1, a, 1, 0, we, la, ld);
    for (int k = 0; k < 8 && !got; k++) cycle(0, '0, 1, 0, 0, '0, '0);
    if (!got) begin
      nvec++;
      nfail++;
      $display("FAIL fetch1_timeout addr %h: got none, want response", a);
    end
    d = pop_d;
    e = pop_e;
  endtask

  initial begin
    int          p;
    int          idx;
    logic [31:0] d;
    logic        e;

    tbl[0] = '{32'h0000_0000, 32'd1,    1'b0};
    tbl[1] = '{32'h0000_0004, 32'd4,    1'b0};
    tbl[2] = '{32'h0000_001C, 32'd22,   1'b0};
    tbl[3] = '{32'h0000_0002, 32'h13,   1'b1};
    tbl[4] = '{32'h0000_1000, 32'h13,   1'b1};
    tbl[5] = '{32'h0000_0FFC, 32'd3070, 1'b0};
    tbl[6] = '{32'hFFFF_FFFC, 32'h13,   1'b1};
    tbl[7] = '{32'h0000_1001, 32'h13,   1'b1};

    req_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid_ro), 32'd0);
    chk("rst_data", rsp_data_ro, 32'd0);
    chk("rst_err", 32'(rsp_err_ro), 32'd0);
    rst_n = 1'b1;
    req_valid_i = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 1024; i++)
      cycle(0, '0, 0, 0, 1, 10'(i), 32'(i * 3 + 1));

    p = npop;
    for (int i = 0; i < 8; i++) cycle(1, 32'(i * 4), 1, 0, 0, '0, '0);
    repeat (4) cycle(0, '0, 1, 0, 0, '0, '0);
    chk("stream_count", 32'(npop - p), 32'd8);

    idx = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1, 32'(idx * 4 + 64), 0, 0, 0, '0, '0);
      if (last_fire) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    for (int k = 0; k < 20; k++) begin
      cycle(idx < 6, 32'(idx * 4 + 64), 1, 0, 0, '0, '0);
      if (last_fire) idx++;
    end
    chk("bp_total", 32'(idx), 32'd6);
    chk("bp_drained", 32'(q.size()), 32'd0);

    for (int t = 0; t < 8; t++) begin
      fetch1(tbl[t].a, 0, '0, '0, d, e);
      chk($sformatf("tbl%0d_data", t), d, tbl[t].d);
      chk($sformatf("tbl%0d_err", t), 32'(e), 32'(tbl[t].e));
    end

    p = npop;
    for (int k = 0; k < 3; k++) cycle(1, 32'(k * 4 + 40), 0, 0, 0, '0, '0);
    cycle(1, 32'h0, 0, 1, 0, '0, '0);
    fetch1(32'h8, 0, '0, '0, d, e);
    repeat (4) cycle(0, '0, 1, 0, 0, '0, '0);
    chk("flush_count", 32'(npop - p), 32'd1);
    chk("flush_data", d, 32'd7);

    cycle(0, '0, 1, 0, 1, 10'd5, 32'hAAAA_0005);
    fetch1(32'h14, 1, 10'd5, 32'hBBBB_0005, d, e);
    chk("coll_old", d, 32'hAAAA_0005);
    fetch1(32'h14, 0, '0, '0, d, e);
    chk("coll_new", d, 32'hBBBB_0005);

    cycle(1, 32'h0, 0, 0, 0, '0, '0);
    cycle(1, 32'h4, 0, 0, 0, '0, '0);
    cycle(1, 32'h8, 0, 0, 0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid_ro), 32'd0);
    chk("arst_data", rsp_data_ro, 32'd0);
    chk("arst_err", 32'(rsp_err_ro), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fetch1(32'h4, 0, '0, '0, d, e);
    chk("arst_recover", d, 32'd4);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom
          : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
            10'($urandom_range(0, 1023)), $urandom);
    end
    repeat (12) cycle(0, '0, 1, 0, 0, '0, '0);
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
